// File: rtl/bf_pkg.sv
// Shared types for the Brainfuck CPU: opcode encodings, sequencer states,
// and the default program-address width.
package bf_pkg;

    localparam int unsigned BF_ADDR_W = 10;

    typedef enum logic [2:0] {
        OP_IN   = 3'b000,
        OP_OUT  = 3'b001,
        OP_BACK = 3'b010,
        OP_IF   = 3'b011,
        OP_MOVL = 3'b100,
        OP_MOVR = 3'b101,
        OP_DEC  = 3'b110,
        OP_INC  = 3'b111
    } bf_op_t;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_EXEC,
        SEQ_SKIP,
        SEQ_HALT,
        SEQ_ERROR
    } bf_seq_state_t;

endpackage

// File: rtl/bf_loop_stack.sv
// Loop-return stack: LIFO of '[' addresses used by the sequencer for ']' jumps.
module bf_loop_stack #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] din_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam logic [PTR_W:0]   SP_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] IDX_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W:0]    sp_q, sp_d;
    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [PTR_W-1:0]  top_idx;

    always_comb begin
        sp_d = sp_q;
        if (clr_i) begin
            sp_d = '0;
        end else if (push_i) begin
            sp_d = sp_q + SP_ONE;
        end else if (pop_i) begin
            sp_d = sp_q - SP_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clr_i) begin
            mem_q[sp_q[PTR_W-1:0]] <= din_i;
        end
    end

    assign top_idx = sp_q[PTR_W-1:0] - IDX_ONE;
    assign top_o   = mem_q[top_idx];
    assign empty_o = (sp_q == '0);
    assign full_o  = sp_q[PTR_W];

    a_no_push_pop: assert property (@(posedge clk) disable iff (rst) !(push_i && pop_i));

endmodule

// File: rtl/bf_sequencer.sv
// Brainfuck instruction sequencer: pc, opcode decode, loop stack and skip scan.
// Optional retired-instruction counter enabled by defining BF_SEQ_STATS_EN.
module bf_sequencer
    import bf_pkg::*;
#(
    parameter int unsigned ADDR_W      = BF_ADDR_W,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_code,
    input  logic              rom_overrun,
    input  logic              cell_zero,
    output logic              op_valid,
    output logic [2:0]        op_code,
    input  logic              op_ready,
    output logic              busy,
    output logic              halted,
    output logic              error
`ifdef BF_SEQ_STATS_EN
    ,
    output logic [31:0]       retired
`endif
);

    localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   DEPTH_ONE = {{ADDR_W{1'b0}}, 1'b1};

    bf_seq_state_t     state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic [ADDR_W:0]   depth_q, depth_d;
    logic              stk_push, stk_pop, stk_clr, stk_empty, stk_full;
    logic [ADDR_W-1:0] stk_top;
    bf_op_t            op;

    assign op     = bf_op_t'(rom_code);
    assign pc_inc = pc_q + PC_ONE;

    bf_loop_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (stk_clr),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .din_i   (pc_q),
        .top_o   (stk_top),
        .empty_o (stk_empty),
        .full_o  (stk_full)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        depth_d  = depth_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;
        op_valid = 1'b0;
        case (state_q)
            SEQ_EXEC: begin
                if (rom_overrun) begin
                    state_d = SEQ_HALT;
                end else begin
                    case (op)
                        OP_IF: begin
                            if (cell_zero) begin
                                depth_d = DEPTH_ONE;
                                pc_d    = pc_inc;
                                state_d = SEQ_SKIP;
                            end else if (stk_full) begin
                                state_d = SEQ_ERROR;
                            end else begin
                                stk_push = 1'b1;
                                pc_d     = pc_inc;
                            end
                        end
                        OP_BACK: begin
                            // Non-zero cell re-enters the body just past the matching '['.
                            if (stk_empty) begin
                                state_d = SEQ_ERROR;
                            end else if (!cell_zero) begin
                                pc_d = stk_top + PC_ONE;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = pc_inc;
                            end
                        end
                        default: begin
                            op_valid = 1'b1;
                            if (op_ready) begin
                                pc_d = pc_inc;
                            end
                        end
                    endcase
                end
            end
            SEQ_SKIP: begin
                if (rom_overrun) begin
                    state_d = SEQ_ERROR;
                end else begin
                    pc_d = pc_inc;
                    if (op == OP_IF) begin
                        depth_d = depth_q + DEPTH_ONE;
                    end else if (op == OP_BACK) begin
                        depth_d = depth_q - DEPTH_ONE;
                        if (depth_q == DEPTH_ONE) begin
                            state_d = SEQ_EXEC;
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = SEQ_EXEC;
                    pc_d    = '0;
                    depth_d = '0;
                    stk_clr = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
            pc_q    <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
        end
    end

    assign rom_addr = pc_q;
    assign op_code  = rom_code;
    assign busy     = (state_q == SEQ_EXEC) || (state_q == SEQ_SKIP);
    assign halted   = (state_q == SEQ_HALT);
    assign error    = (state_q == SEQ_ERROR);

`ifdef BF_SEQ_STATS_EN
    logic        retire;
    logic [31:0] retired_q, retired_d;

    // Every IF/BACK decoded in EXEC counts, including one that faults.
    assign retire = (state_q == SEQ_EXEC) && !rom_overrun &&
                    ((op == OP_IF) || (op == OP_BACK) || op_ready);

    always_comb begin
        retired_d = retired_q;
        if (stk_clr) begin
            retired_d = '0;
        end else if (retire && (retired_q != '1)) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_bf_sequencer.sv
// Self-checking bench for bf_sequencer: behavioural ROM and datapath models,
// op scoreboard, and directed programs covering loops, skips and faults.
module tb_bf_sequencer;

    localparam int unsigned AW = 10;
    localparam int unsigned SD = 16;

    logic          clk = 1'b0;
    logic          rst, start, op_ready;
    logic          rom_overrun, cell_zero;
    logic [AW-1:0] rom_addr;
    logic [2:0]    rom_code, op_code;
    logic          op_valid, busy, halted, error;
`ifdef BF_SEQ_STATS_EN
    logic [31:0]   retired;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int s0    = 0;

    logic [2:0] rom [0:31];
    int         rom_len = 0;
    logic [7:0] tape [0:31];
    logic [4:0] ptr = '0;
    logic       force_cz_en = 1'b0;
    logic       force_cz    = 1'b0;

    logic [2:0]    exp_q [$];
    int            acc_n = 0, last_acc = 0, jump_n = 0, valid_n = 0;
    logic [AW-1:0] prev_addr = '0;

    bf_sequencer #(
        .ADDR_W      (AW),
        .STACK_DEPTH (SD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_code    (rom_code),
        .rom_overrun (rom_overrun),
        .cell_zero   (cell_zero),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .op_ready    (op_ready),
        .busy        (busy),
        .halted      (halted),
        .error       (error)
`ifdef BF_SEQ_STATS_EN
        ,
        .retired     (retired)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rom_overrun = (int'(rom_addr) >= rom_len);
    assign rom_code    = rom[rom_addr[4:0]];
    assign cell_zero   = force_cz_en ? force_cz : (tape[ptr] == 8'd0);

    // Datapath model: cell updates become visible the cycle after acceptance.
    always @(posedge clk) begin
        if (start) begin
            for (int i = 0; i < 32; i++) tape[i] <= 8'd0;
            ptr <= '0;
        end else if (op_valid && op_ready) begin
            case (op_code)
                3'b111:  tape[ptr] <= tape[ptr] + 8'd1;
                3'b110:  tape[ptr] <= tape[ptr] - 8'd1;
                3'b101:  ptr <= ptr + 5'd1;
                3'b100:  ptr <= ptr - 5'd1;
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (op_valid) valid_n++;
        if (busy && prev_addr == 10'd4 && rom_addr == 10'd3) jump_n++;
        prev_addr = rom_addr;
        if (op_valid && op_ready) begin
            acc_n++;
            last_acc = cyc;
            if (exp_q.size() == 0) check("sb_extra_op", 32'(op_code), 32'hFFFF_FFFF);
            else                   check("sb_op", 32'(op_code), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "+":     rom[i] = 3'b111;
                "-":     rom[i] = 3'b110;
                ">":     rom[i] = 3'b101;
                "<":     rom[i] = 3'b100;
                "[":     rom[i] = 3'b011;
                "]":     rom[i] = 3'b010;
                ".":     rom[i] = 3'b001;
                default: rom[i] = 3'b000;
            endcase
        end
        rom_len = s.len();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        s0 = cyc;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(halted || error) && n < budget) begin
            tick();
            n++;
        end
        if (!(halted || error)) check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        string deep;
        int    a0, v0;
        rst = 1'b1; start = 1'b0; op_ready = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 3'b000;
        tick(); tick();
        check("rst_valid",  32'(op_valid), 32'd0);
        check("rst_busy",   32'(busy),     32'd0);
        check("rst_halted", 32'(halted),   32'd0);
        check("rst_error",  32'(error),    32'd0);
        check("rst_addr",   32'(rom_addr), 32'd0);
`ifdef BF_SEQ_STATS_EN
        check("rst_retired", retired, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // +++. at full throughput
        load("+++.");
        op_ready = 1'b1;
        exp_q.push_back(3'b111); exp_q.push_back(3'b111);
        exp_q.push_back(3'b111); exp_q.push_back(3'b001);
        a0 = acc_n;
        do_start();
        wait_end(20);
        check("t1_halt_cycle", 32'(cyc - s0 + 1), 32'd6);
        check("t1_accepts",    32'(acc_n - a0),   32'd4);
        check("t1_last_acc",   32'(last_acc - s0 + 1), 32'd4);
        check("t1_q_empty",    32'(exp_q.size()), 32'd0);
`ifdef BF_SEQ_STATS_EN
        check("t1_retired", retired, 32'd4);
`endif

        // back-pressure on the first op
        op_ready = 1'b0;
        exp_q.push_back(3'b111); exp_q.push_back(3'b111);
        exp_q.push_back(3'b111); exp_q.push_back(3'b001);
        do_start();
        for (int i = 0; i < 3; i++) begin
            check("t2_valid",   32'(op_valid), 32'd1);
            check("t2_code",    32'(op_code),  32'd7);
            check("t2_addr",    32'(rom_addr), 32'd0);
            tick();
        end
        check("t2_addr_hold", 32'(rom_addr), 32'd0);
        op_ready = 1'b1;
        tick();
        check("t2_addr_adv", 32'(rom_addr), 32'd1);
        wait_end(20);
        check("t2_halted",  32'(halted), 32'd1);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // ++[-] with the datapath model
        load("++[-]");
        exp_q.push_back(3'b111); exp_q.push_back(3'b111);
        exp_q.push_back(3'b110); exp_q.push_back(3'b110);
        jump_n = 0;
        do_start();
        wait_end(40);
        check("t3_halted",    32'(halted), 32'd1);
        check("t3_error",     32'(error),  32'd0);
        check("t3_jumps",     32'(jump_n), 32'd1);
        check("t3_q_empty",   32'(exp_q.size()), 32'd0);
        check("t3_stk_empty", 32'(dut.u_stack.empty_o), 32'd1);
`ifdef BF_SEQ_STATS_EN
        check("t3_retired", retired, 32'd7);
`endif

        // [+[+]+] skipped entirely
        load("[+[+]+]");
        force_cz_en = 1'b1; force_cz = 1'b1;
        v0 = valid_n;
        do_start();
        check("t4_addr0", 32'(rom_addr), 32'd0);
        tick();
        for (int k = 1; k <= 6; k++) begin
            check("t4_skip_addr",  32'(rom_addr), 32'(k));
            check("t4_skip_valid", 32'(op_valid), 32'd0);
            tick();
        end
        check("t4_resume_addr", 32'(rom_addr), 32'd7);
        check("t4_resume_busy", 32'(busy),     32'd1);
        wait_end(10);
        check("t4_halted",  32'(halted), 32'd1);
        check("t4_nvalid",  32'(valid_n - v0), 32'd0);
`ifdef BF_SEQ_STATS_EN
        check("t4_retired", retired, 32'd1);
`endif
        force_cz_en = 1'b0;

        // lone ]
        load("]");
        do_start();
        check("t5_err_pre", 32'(error), 32'd0);
        tick();
        check("t5_err",  32'(error), 32'd1);
        check("t5_busy", 32'(busy),  32'd0);

        // nesting one level past the stack depth
        deep = "";
        for (int i = 0; i < SD + 1; i++) deep = {deep, "["};
        load(deep);
        force_cz_en = 1'b1; force_cz = 1'b0;
        do_start();
        repeat (SD) tick();
        check("t5_deep_pre",  32'(error),    32'd0);
        check("t5_deep_addr", 32'(rom_addr), 32'(SD));
        tick();
        check("t5_deep_err",  32'(error),    32'd1);
        tick();
        check("t5_pc_frozen", 32'(rom_addr), 32'(SD));
`ifdef BF_SEQ_STATS_EN
        check("t5_retired", retired, 32'(SD + 1));
`endif
        force_cz_en = 1'b0;

        // asynchronous reset mid-handshake
        load("+++.");
        op_ready = 1'b1;
        exp_q.push_back(3'b111);
        do_start();
        tick();
        op_ready = 1'b0;
        check("t6_addr_pre",  32'(rom_addr), 32'd1);
        check("t6_valid_pre", 32'(op_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(op_valid), 32'd0);
        check("t6_addr",  32'(rom_addr), 32'd0);
        check("t6_busy",  32'(busy),     32'd0);
`ifdef BF_SEQ_STATS_EN
        check("t6_retired", retired, 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        check("t6_idle",    32'(busy), 32'd0);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
